// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
// Samples per-point toggle strobes, keeps a sticky bitmap of points seen,
// and streams newly hit points out as global cover indices over valid/ready.
// Simultaneous hits wait in a pending bitmap and drain lowest index first.
module cover_toggle_collector #(
  parameter int              WIDTH       = 16,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 38253,
  parameter int              DEDUP       = 1,
  parameter int              CNT_W       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_index,
  output logic [$clog2(WIDTH+1)-1:0]   covered_count,
  output logic                         all_covered,
  output logic [CNT_W-1:0]             coalesced_count
);

  localparam int          CCW  = $clog2(WIDTH + 1);
  localparam int          PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          SUMW = CNT_W + CCW;
  localparam logic [63:0] BASE = 64'(COVER_INDEX);

  // Reject parameter sets that would report indices outside the design-wide range.
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be in 1..1024");
  end
  if (COVER_INDEX + longint'(WIDTH) > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] covered_next;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] absorbed;
  logic [PW-1:0]    lowest_pos;
  logic             load;
  logic [CCW-1:0]   absorbed_hits;
  logic [CCW-1:0]   covered_sum;
  logic [SUMW-1:0]  coalesced_sum;
  logic [CNT_W-1:0] coalesced_next;

  // Find the lowest pending bit; scanning downward lets the lowest one win.
  always_comb begin
    lowest_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) lowest_pos = PW'(i);
    end
  end

  // Move a pending bit into the output register whenever that register is free or draining.
  always_comb begin
    load = (!out_valid || out_ready) && (|pending);
    sel  = load ? (WIDTH'(1) << lowest_pos) : '0;
  end

  // Next-state bitmaps; a clear wipes history but keeps hits arriving in the same cycle.
  always_comb begin
    covered_next = covered | valid;
    pending_next = (pending & ~sel) | valid;
    absorbed     = '0;
    if (clear) begin
      covered_next = valid;
      pending_next = valid & ~sel;
    end else if (DEDUP != 0) begin
      pending_next = (pending & ~sel) | (valid & ~covered);
    end else begin
      absorbed = valid & pending & ~sel;
    end
  end

  // Population counts for absorbed repeats and for the covered bitmap.
  always_comb begin
    absorbed_hits = '0;
    covered_sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      absorbed_hits = absorbed_hits + CCW'(absorbed[i]);
      covered_sum   = covered_sum + CCW'(covered_next[i]);
    end
  end

  // Saturating accumulation of repeats that landed on an already-pending point.
  always_comb begin
    coalesced_sum = SUMW'(coalesced_count) + SUMW'(absorbed_hits);
    if (coalesced_sum[SUMW-1:CNT_W] != '0) begin
      coalesced_next = '1;
    end else begin
      coalesced_next = coalesced_sum[CNT_W-1:0];
    end
  end

  // Register bitmaps, statistics and the output report slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      covered         <= '0;
      pending         <= '0;
      out_valid       <= 1'b0;
      out_index       <= '0;
      covered_count   <= '0;
      all_covered     <= 1'b0;
      coalesced_count <= '0;
    end else begin
      covered         <= covered_next;
      pending         <= pending_next;
      covered_count   <= covered_sum;
      all_covered     <= &covered_next;
      coalesced_count <= coalesced_next;
      if (load) begin
        out_valid <= 1'b1;
        out_index <= BASE + 64'(lowest_pos);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
